// File: rtl/fwd_hazard_unit_if.sv
// Purpose: bundles the ID/EX decode fields, forwarding-stage write-backs and hazard outputs of fwd_hazard_unit.
// Latency: pure wiring; no storage of its own.
// Backpressure: none here; the unit's stall_id is the only hold signal carried back to the pipeline.
interface fwd_hazard_if #(
    parameter int AW      = 5,
    parameter int NSTAGE  = 2,
    parameter int MAX_LAT = 8,
    parameter int LW      = $clog2(MAX_LAT + 1),
    parameter int SW      = $clog2(NSTAGE + 1)
);
    // ID stage
    logic              id_valid;
    logic [AW-1:0]     id_rs1;
    logic [AW-1:0]     id_rs2;
    logic [AW-1:0]     id_rd;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_regwen;
    // EX stage
    logic              ex_valid;
    logic [AW-1:0]     ex_rs1;
    logic [AW-1:0]     ex_rs2;
    logic [AW-1:0]     ex_rd;
    logic              ex_regwen;
    logic              ex_is_load;
    logic              ex_is_long;
    logic [LW-1:0]     ex_lat;
    logic              ex_flush;
    // forwarding sources, stage 0 = youngest
    logic [NSTAGE*AW-1:0] stg_rd;
    logic [NSTAGE-1:0]    stg_regwen;
    // results
    logic [SW-1:0]     fwd_a;
    logic [SW-1:0]     fwd_b;
    logic              stall_id;
    logic              sb_busy;
    logic [31:0]       stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwen,
        output ex_valid, ex_rs1, ex_rs2, ex_rd, ex_regwen, ex_is_load, ex_is_long,
        output ex_lat, ex_flush, stg_rd, stg_regwen,
        input  fwd_a, fwd_b, stall_id, sb_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_regwen,
        input  ex_valid, ex_rs1, ex_rs2, ex_rd, ex_regwen, ex_is_load, ex_is_long,
        input  ex_lat, ex_flush, stg_rd, stg_regwen,
        output fwd_a, fwd_b, stall_id, sb_busy, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Purpose: EX operand forwarding over NSTAGE write-back sources plus load-use / multi-cycle hazard stall for ID.
// Latency: fwd_a/fwd_b/stall_id are combinational; scoreboard entries load on the issue edge and count down 1 per cycle.
// Backpressure: stall_id holds IF/ID and bubbles EX; EX itself is never gated by this block.
module fwd_hazard_unit #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int NSTAGE  = 2,
    parameter int MAX_LAT = 8,
    parameter int LW      = $clog2(MAX_LAT + 1),
    parameter int SW      = $clog2(NSTAGE + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_if.slave  bus
);

    // one countdown per architectural register; nonzero means result not yet in the regfile
    logic [NREG-1:0][LW-1:0] cnt_q;
    logic [NREG-1:0]         pend;
    logic                    issue;
    logic [LW-1:0]           lat_eff;
    logic [SW-1:0]           fwd_a_c;
    logic [SW-1:0]           fwd_b_c;
    logic                    src1_used;
    logic                    src2_used;
    logic                    load_use;
    logic                    raw_long;
    logic                    waw_long;
    logic                    stall_c;
    logic [31:0]             stall_cnt_q;

    // youngest matching stage wins: scan oldest-to-youngest so the last hit is the youngest
    function automatic logic [SW-1:0] fwd_sel(
        input logic [AW-1:0]        rs,
        input logic [NSTAGE*AW-1:0] rd_vec,
        input logic [NSTAGE-1:0]    wen_vec
    );
        logic [SW-1:0] sel;
        sel = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (wen_vec[k] && (rd_vec[k*AW +: AW] != '0) && (rd_vec[k*AW +: AW] == rs)) begin
                sel = SW'(k + 1);
            end
        end
        return sel;
    endfunction

    // forwarding selects, forced to regfile when EX holds no instruction
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        if (bus.ex_valid) begin
            fwd_a_c = fwd_sel(bus.ex_rs1, bus.stg_rd, bus.stg_regwen);
            fwd_b_c = fwd_sel(bus.ex_rs2, bus.stg_rd, bus.stg_regwen);
        end
    end

    // multi-cycle issue qualification and latency clamp; zero latency means result is already available
    always_comb begin
        issue   = bus.ex_valid && !bus.ex_flush && bus.ex_is_long && bus.ex_regwen
                  && (bus.ex_rd != '0) && (bus.ex_lat != '0);
        lat_eff = (bus.ex_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : bus.ex_lat;
    end

    // scoreboard: issue reloads (and beats decrement), otherwise count down to zero; x0 stays empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    cnt_q[r] <= '0;
                end else if (issue && (bus.ex_rd == AW'(r))) begin
                    cnt_q[r] <= lat_eff;
                end else if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // per-register pending flags
    always_comb begin
        pend = '0;
        for (int r = 0; r < NREG; r++) begin
            pend[r] = (cnt_q[r] != '0);
        end
    end

    // hazard detection; x0 sources and destinations never stall
    always_comb begin
        src1_used = bus.id_use_rs1 && (bus.id_rs1 != '0);
        src2_used = bus.id_use_rs2 && (bus.id_rs2 != '0);
        load_use  = bus.ex_valid && !bus.ex_flush && bus.ex_is_load && bus.ex_regwen
                    && (bus.ex_rd != '0)
                    && ((src1_used && (bus.id_rs1 == bus.ex_rd))
                        || (src2_used && (bus.id_rs2 == bus.ex_rd)));
        raw_long  = (src1_used && pend[bus.id_rs1]) || (src2_used && pend[bus.id_rs2]);
        waw_long  = bus.id_regwen && (bus.id_rd != '0) && pend[bus.id_rd];
        stall_c   = bus.id_valid && (load_use || raw_long || waw_long);
    end

    // saturating count of stalled decode cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.fwd_a     = fwd_a_c;
    assign bus.fwd_b     = fwd_b_c;
    assign bus.stall_id  = stall_c;
    assign bus.sb_busy   = |pend;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Purpose: self-checking bench for fwd_hazard_unit: vector table, directed multi-cycle sequences, random vs timestamp model.
// Latency: outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Backpressure: n/a (bench drives the EX stream freely, as the unit never gates EX).
module tb_fwd_hazard_unit;
    localparam int NREG = 32, AW = 5, NSTAGE = 2, MAX_LAT = 8;
    localparam int LW = $clog2(MAX_LAT + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_if #(.AW(AW), .NSTAGE(NSTAGE), .MAX_LAT(MAX_LAT)) bus ();

    fwd_hazard_unit #(.NREG(NREG), .AW(AW), .NSTAGE(NSTAGE), .MAX_LAT(MAX_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: absolute cycle at which each register's result becomes readable
    longint now_cyc = 0;
    longint ready [NREG];
    longint m_stall = 0;

    logic [1:0] obs_fa, obs_fb;
    logic       obs_stall, obs_busy;

    typedef struct {
        logic       id_valid;
        logic [4:0] id_rs1, id_rs2, id_rd;
        logic       use1, use2, idw;
        logic       ex_valid;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       exw, ld, flush;
        logic [4:0] s1_rd, s0_rd;
        logic [1:0] s_wen;
        logic [1:0] e_fa, e_fb;
        logic       e_st;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit m_pend(input int r);
        return (r != 0) && (now_cyc < ready[r]);
    endfunction

    function automatic int m_fwd(input int rs);
        int rd;
        if (!bus.ex_valid) return 0;
        for (int k = 0; k < NSTAGE; k++) begin
            rd = int'(bus.stg_rd[k*AW +: AW]);
            if (bus.stg_regwen[k] && rd != 0 && rd == rs) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < NREG; r++) if (m_pend(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall_now();
        int r1, r2, rd, xd;
        bit u1, u2, lu, raw, waw;
        r1 = int'(bus.id_rs1); r2 = int'(bus.id_rs2);
        rd = int'(bus.id_rd);  xd = int'(bus.ex_rd);
        u1 = bus.id_use_rs1 && r1 != 0;
        u2 = bus.id_use_rs2 && r2 != 0;
        lu = bus.ex_valid && !bus.ex_flush && bus.ex_is_load && bus.ex_regwen && xd != 0
             && ((u1 && r1 == xd) || (u2 && r2 == xd));
        raw = (u1 && m_pend(r1)) || (u2 && m_pend(r2));
        waw = bus.id_regwen && rd != 0 && m_pend(rd);
        return bus.id_valid && (lu || raw || waw);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) ready[r] = 0;
        m_stall = 0;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_regwen = 0;
        bus.ex_valid = 0; bus.ex_rs1 = 0; bus.ex_rs2 = 0; bus.ex_rd = 0;
        bus.ex_regwen = 0; bus.ex_is_load = 0; bus.ex_is_long = 0; bus.ex_lat = 0;
        bus.ex_flush = 0; bus.stg_rd = 0; bus.stg_regwen = 0;
    endtask

    task automatic clear_ex();
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_regwen = 0; bus.ex_is_load = 0;
        bus.ex_is_long = 0; bus.ex_lat = 0; bus.ex_flush = 0;
    endtask

    task automatic set_issue(input int rd, input int lat);
        bus.ex_valid = 1; bus.ex_is_long = 1; bus.ex_regwen = 1; bus.ex_is_load = 0;
        bus.ex_flush = 0; bus.ex_rd = AW'(rd); bus.ex_lat = LW'(lat);
    endtask

    // one clock: check every output against the model, then advance the model across the edge
    task automatic run_cycle(input string tag);
        bit es;
        int lat;
        @(negedge clk);
        es = m_stall_now();
        obs_fa = bus.fwd_a; obs_fb = bus.fwd_b;
        obs_stall = bus.stall_id; obs_busy = bus.sb_busy;
        chk({tag, ".fwd_a"},     64'(obs_fa),        64'(m_fwd(int'(bus.ex_rs1))));
        chk({tag, ".fwd_b"},     64'(obs_fb),        64'(m_fwd(int'(bus.ex_rs2))));
        chk({tag, ".stall_id"},  64'(obs_stall),     64'(es));
        chk({tag, ".sb_busy"},   64'(obs_busy),      64'(m_busy()));
        chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(m_stall));
        if (es && m_stall != 64'hFFFF_FFFF) m_stall++;
        if (bus.ex_valid && !bus.ex_flush && bus.ex_is_long && bus.ex_regwen
            && bus.ex_rd != 0 && bus.ex_lat != 0) begin
            lat = (int'(bus.ex_lat) > MAX_LAT) ? MAX_LAT : int'(bus.ex_lat);
            ready[int'(bus.ex_rd)] = now_cyc + lat + 1;
        end
        now_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic iv, input int r1, input int r2, input int rd, input logic u1, input logic u2, input logic iw,
        input logic ev, input int x1, input int x2, input int xd, input logic xw, input logic ld, input logic fl,
        input int s1, input int s0, input logic [1:0] sw, input int fa, input int fb, input logic st);
        vec_t v;
        v.id_valid = iv; v.id_rs1 = 5'(r1); v.id_rs2 = 5'(r2); v.id_rd = 5'(rd);
        v.use1 = u1; v.use2 = u2; v.idw = iw;
        v.ex_valid = ev; v.ex_rs1 = 5'(x1); v.ex_rs2 = 5'(x2); v.ex_rd = 5'(xd);
        v.exw = xw; v.ld = ld; v.flush = fl;
        v.s1_rd = 5'(s1); v.s0_rd = 5'(s0); v.s_wen = sw;
        v.e_fa = 2'(fa); v.e_fb = 2'(fb); v.e_st = st;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_waw [6];
        int n;
        exp_waw = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // forwarding vectors
        vt.push_back(mk(0,0,0,0,0,0,0, 1,5,3,0,0,0,0, 5,5,2'b11, 1,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,5,3,0,0,0,0, 5,5,2'b10, 2,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,0,0,0,0,0,0, 0,0,2'b11, 0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 0,5,5,0,0,0,0, 5,5,2'b11, 0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,6,6,0,0,0,0, 6,2,2'b11, 2,2,0));
        vt.push_back(mk(0,0,0,0,0,0,0, 1,2,6,0,0,0,0, 6,2,2'b01, 1,0,0));
        // load-use vectors
        vt.push_back(mk(1,1,7,3,1,1,1, 1,0,0,7,1,1,0, 0,0,2'b00, 0,0,1));
        vt.push_back(mk(1,1,3,3,1,1,1, 1,0,0,9,1,0,0, 0,0,2'b00, 0,0,0));
        vt.push_back(mk(1,1,7,3,1,1,1, 1,0,0,7,1,1,1, 0,0,2'b00, 0,0,0));
        vt.push_back(mk(1,1,7,3,1,0,1, 1,0,0,7,1,1,0, 0,0,2'b00, 0,0,0));
        vt.push_back(mk(0,1,7,3,1,1,1, 1,0,0,7,1,1,0, 0,0,2'b00, 0,0,0));
        vt.push_back(mk(1,0,0,0,1,1,0, 1,0,0,0,1,1,0, 0,0,2'b00, 0,0,0));
        vt.push_back(mk(1,7,2,3,1,1,1, 1,0,0,7,1,1,0, 0,0,2'b00, 0,0,1));
        vt.push_back(mk(1,7,2,3,1,1,1, 1,0,0,7,0,1,0, 0,0,2'b00, 0,0,0));
        vt.push_back(mk(1,7,2,3,1,1,1, 0,0,0,7,1,1,0, 0,0,2'b00, 0,0,0));

        // reset state, sampled mid-cycle while rst_n is low
        idle();
        model_reset();
        rst_n = 0;
        #12;
        chk("reset.stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("reset.sb_busy",   64'(bus.sb_busy),   64'd0);
        chk("reset.stall_id",  64'(bus.stall_id),  64'd0);
        chk("reset.fwd_a",     64'(bus.fwd_a),     64'd0);
        chk("reset.fwd_b",     64'(bus.fwd_b),     64'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // table vectors
        foreach (vt[i]) begin
            idle();
            bus.id_valid = vt[i].id_valid; bus.id_rs1 = vt[i].id_rs1; bus.id_rs2 = vt[i].id_rs2;
            bus.id_rd = vt[i].id_rd; bus.id_use_rs1 = vt[i].use1; bus.id_use_rs2 = vt[i].use2;
            bus.id_regwen = vt[i].idw; bus.ex_valid = vt[i].ex_valid; bus.ex_rs1 = vt[i].ex_rs1;
            bus.ex_rs2 = vt[i].ex_rs2; bus.ex_rd = vt[i].ex_rd; bus.ex_regwen = vt[i].exw;
            bus.ex_is_load = vt[i].ld; bus.ex_flush = vt[i].flush;
            bus.stg_rd = {vt[i].s1_rd, vt[i].s0_rd}; bus.stg_regwen = vt[i].s_wen;
            run_cycle("vec");
            chk($sformatf("vec%0d.fwd_a", i),    64'(obs_fa),    64'(vt[i].e_fa));
            chk($sformatf("vec%0d.fwd_b", i),    64'(obs_fb),    64'(vt[i].e_fb));
            chk($sformatf("vec%0d.stall_id", i), 64'(obs_stall), 64'(vt[i].e_st));
        end

        // long op: mul x9 lat 3, dependent reader stalls exactly 3 cycles
        do_reset();
        set_issue(9, 3);
        run_cycle("mul_issue");
        idle();
        bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 9;
        for (int i = 0; i < 4; i++) begin
            run_cycle("mul_wait");
            chk($sformatf("mul_stall%0d", i), 64'(obs_stall), 64'(i < 3));
            chk($sformatf("mul_busy%0d", i),  64'(obs_busy),  64'(i < 3));
        end
        chk("mul_stall_cnt", 64'(bus.stall_cnt), 64'd3);

        // WAW and reload: x4 lat 5, then x4 lat 2 two cycles later; ID writes x4 throughout
        do_reset();
        bus.id_valid = 1; bus.id_regwen = 1; bus.id_rd = 4;
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      set_issue(4, 5);
            else if (i == 2) set_issue(4, 2);
            else             clear_ex();
            run_cycle("waw");
            chk($sformatf("waw_stall%0d", i), 64'(obs_stall), 64'(exp_waw[i]));
        end

        // clamp: latency above MAX_LAT keeps the entry busy for exactly MAX_LAT cycles
        do_reset();
        set_issue(10, MAX_LAT + 3);
        run_cycle("clamp_issue");
        idle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            run_cycle("clamp");
            if (obs_busy) n++;
        end
        chk("clamp_len", 64'(n), 64'(MAX_LAT));

        // zero latency creates no entry
        set_issue(11, 0);
        run_cycle("zero_issue");
        idle();
        run_cycle("zero");
        chk("zero_lat_busy", 64'(obs_busy), 64'd0);

        // reset mid-operation with three pending entries and a stalled reader
        do_reset();
        set_issue(1, 8); run_cycle("rst_iss");
        set_issue(2, 8); run_cycle("rst_iss");
        set_issue(3, 8); run_cycle("rst_iss");
        idle();
        bus.id_valid = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 1;
        run_cycle("rst_pre");
        #2;
        chk("rst_pre.stall_id", 64'(bus.stall_id), 64'd1);
        chk("rst_pre.sb_busy",  64'(bus.sb_busy),  64'd1);
        rst_n = 0;
        #1;
        chk("rst_async.sb_busy",   64'(bus.sb_busy),   64'd0);
        chk("rst_async.stall_id",  64'(bus.stall_id),  64'd0);
        chk("rst_async.stall_cnt", 64'(bus.stall_cnt), 64'd0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // randomized traffic against the timestamp model
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset();
            bus.id_valid   = 1'($urandom_range(0, 3) != 0);
            bus.id_rs1     = 5'($urandom_range(0, 7));
            bus.id_rs2     = 5'($urandom_range(0, 7));
            bus.id_rd      = 5'($urandom_range(0, 7));
            bus.id_use_rs1 = 1'($urandom);
            bus.id_use_rs2 = 1'($urandom);
            bus.id_regwen  = 1'($urandom);
            bus.ex_valid   = 1'($urandom_range(0, 3) != 0);
            bus.ex_rs1     = 5'($urandom_range(0, 7));
            bus.ex_rs2     = 5'($urandom_range(0, 7));
            bus.ex_rd      = 5'($urandom_range(0, 7));
            bus.ex_regwen  = 1'($urandom_range(0, 3) != 0);
            bus.ex_is_load = 1'($urandom_range(0, 3) == 0);
            bus.ex_is_long = 1'($urandom_range(0, 3) == 0);
            bus.ex_lat     = LW'($urandom_range(0, 15));
            bus.ex_flush   = 1'($urandom_range(0, 7) == 0);
            bus.stg_rd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            bus.stg_regwen = 2'($urandom);
            run_cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor of the two-source EX forwarding selector.
- Generalises forwarding to NSTAGE write-back sources with youngest-first priority.
- Adds load-use stall detection and a per-register countdown scoreboard for multi-cycle (mul/div) results, producing a decode-stage stall.
- Sits between ID/EX decode and the pipeline register enables; also exposes a saturating stall-cycle perf counter.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero).
- AW, 5, register index width; NREG = 2**AW.
- NSTAGE, 2, forwarding sources; index 0 = youngest (MEM), NSTAGE-1 = oldest (WB).
- MAX_LAT, 8, maximum multi-cycle latency tracked; LW = $clog2(MAX_LAT+1).
- SW, $clog2(NSTAGE+1), forward-select width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  valid instruction in ID
- id_rs1, id_rs2, id_rd  in  AW each  ID register fields
- id_use_rs1, id_use_rs2, id_regwen  in  1 each  ID operand-use and write flags
- ex_valid  in  1  valid instruction in EX
- ex_rs1, ex_rs2, ex_rd  in  AW each  EX register fields
- ex_regwen, ex_is_load, ex_is_long  in  1 each  EX write / load / multi-cycle flags
- ex_lat  in  LW  multi-cycle result latency in cycles (valid with ex_is_long)
- ex_flush  in  1  EX instruction killed this cycle
- stg_rd  in  NSTAGE*AW  destination per forwarding stage, stage k at [k*AW +: AW]
- stg_regwen  in  NSTAGE  write-enable per stage
- fwd_a, fwd_b  out  SW  0 = regfile, k+1 = forward from stage k
- stall_id  out  1  hold IF/ID, inject bubble into EX
- sb_busy  out  1  any scoreboard entry nonzero
- stall_cnt  out  32  saturating count of stall_id cycles

Behaviour:
- Reset (async, rst_n=0): all scoreboard counters 0, stall_cnt 0; outputs follow combinationally: sb_busy 0, stall_id 0, fwd_a/fwd_b 0.
- Forwarding (combinational):
  - fwd_a = k+1 for the smallest k with stg_regwen[k] & stg_rd[k] != 0 & stg_rd[k] == ex_rs1; else 0.
  - fwd_b is identical using ex_rs2.
  - Both are 0 when ex_valid = 0.
- Scoreboard: one LW-bit counter per register; entry 0 is never written.
  - Issue = ex_valid & !ex_flush & ex_is_long & ex_regwen & ex_rd != 0 & ex_lat != 0.
  - On issue: cnt[ex_rd] <= min(ex_lat, MAX_LAT).
  - Every other nonzero counter decrements by 1 each cycle.
  - Issue to a register whose counter is nonzero reloads it; load wins over decrement.
  - Result is in the regfile in the cycle its counter reads 0. pending(r) = cnt[r] != 0.
- Stall (combinational), stall_id = id_valid & (load_use | raw_long | waw_long):
  - load_use: ex_valid & !ex_flush & ex_is_load & ex_regwen & ex_rd != 0, and ex_rd matches a used ID source.
  - raw_long: a used ID source (nonzero) is pending.
  - waw_long: id_regwen & id_rd != 0 & pending(id_rd).
  - Register x0 never causes a stall.
  - The EX instruction always proceeds; the block does not gate EX issue on stall_id.
- sb_busy = OR of all counters != 0.
- stall_cnt increments on each clk with stall_id = 1; holds at 0xFFFF_FFFF.
- ex_lat = 0 with ex_is_long: no entry. ex_lat > MAX_LAT: clamped.

Test Plan:
- Forward priority, NSTAGE=2: stg_rd = {5,5}, both regwen, ex_rs1 = 5 → fwd_a = 1. Drop stage0 regwen → fwd_a = 2. ex_rs1 = 0 with stg_rd = 0 → fwd_a = 0.
- Load-use: EX lw x7; ID add uses x7 on rs2 → stall_id = 1 for exactly that cycle. Same case with ex_flush = 1 → stall_id = 0. Same case with id_use_rs2 = 0 → stall_id = 0.
- Long op: issue mul x9 with ex_lat = 3; ID reads x9 next cycle → stall_id = 1 for 3 cycles, then 0. stall_cnt = 3. sb_busy drops when cnt reaches 0.
- WAW and reload: issue x4 lat 5, then x4 lat 2 two cycles later → cnt[x4] = 2 after reload, pending clears 2 cycles later. ID write to x4 while pending → stall_id = 1.
- Clamp and zero: ex_lat = 0 → no entry, sb_busy = 0. ex_lat = MAX_LAT+3 (LW permitting) → counter = MAX_LAT.
- Reset mid-operation: assert rst_n = 0 with three pending entries → sb_busy = 0, stall_id = 0, stall_cnt = 0 immediately, asynchronous to clk.
